// File: rtl/mtr_pwm_drv.sv
// Dual-channel complementary PWM driver: maps signed wheel speed commands to
// high/low-side H-bridge drives with fixed dead time, updating duty only at period wrap.
module mtr_pwm_drv #(
  parameter int NONOVERLAP = 32,
  parameter int DATA_W     = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] lft_spd,
  input  logic signed [DATA_W-1:0] rght_spd,
  input  logic                     mtr_en,
  output logic                     lft_pwm1,
  output logic                     lft_pwm2,
  output logic                     rght_pwm1,
  output logic                     rght_pwm2,
  output logic                     prd_start
);

  localparam logic [DATA_W-1:0] CNT_MAX  = '1;
  localparam logic [DATA_W-1:0] DUTY_MID = DATA_W'(1) << (DATA_W - 1);
  localparam logic [DATA_W-1:0] NN_CNT   = DATA_W'(NONOVERLAP);
  localparam logic [DATA_W:0]   NN_EXT   = (DATA_W + 1)'(NONOVERLAP);

  // Offset-binary mapping: adding half-scale modulo 2^DATA_W is an MSB flip.
  function automatic logic [DATA_W-1:0] spd_to_duty(input logic signed [DATA_W-1:0] spd);
    return {~spd[DATA_W-1], spd[DATA_W-2:0]};
  endfunction

  logic [DATA_W-1:0]       cnt;
  logic [1:0][DATA_W-1:0]  duty_sh;
  logic [1:0][DATA_W:0]    pwm2_on;
  logic [1:0]              pwm1_q;
  logic [1:0]              pwm2_q;

  // Low-side turn-on point kept one bit wider so an overflow past CNT_MAX never matches.
  always_comb begin
    pwm2_on = '0;
    for (int i = 0; i < 2; i++) begin
      pwm2_on[i] = {1'b0, duty_sh[i]} + NN_EXT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      duty_sh <= {DUTY_MID, DUTY_MID};
      pwm1_q  <= '0;
      pwm2_q  <= '0;
    end else begin
      cnt <= cnt + DATA_W'(1);
      if (cnt == CNT_MAX) begin
        duty_sh[0] <= spd_to_duty(lft_spd);
        duty_sh[1] <= spd_to_duty(rght_spd);
      end
      for (int i = 0; i < 2; i++) begin
        if (!mtr_en) begin
          pwm1_q[i] <= 1'b0;
          pwm2_q[i] <= 1'b0;
        end else begin
          if (cnt >= duty_sh[i]) begin
            pwm1_q[i] <= 1'b0;
          end else if (cnt == NN_CNT) begin
            pwm1_q[i] <= 1'b1;
          end
          if (cnt == CNT_MAX) begin
            pwm2_q[i] <= 1'b0;
          end else if ({1'b0, cnt} == pwm2_on[i]) begin
            pwm2_q[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign lft_pwm1  = pwm1_q[0];
  assign lft_pwm2  = pwm2_q[0];
  assign rght_pwm1 = pwm1_q[1];
  assign rght_pwm2 = pwm2_q[1];
  assign prd_start = (cnt == '0);

endmodule

// File: tb/tb_mtr_pwm_drv.sv
// Scoreboard bench for mtr_pwm_drv: a period-level reference model predicts every
// output cycle, a monitor compares on the falling edge.
`timescale 1ns/1ps
module tb_mtr_pwm_drv;

  localparam int NN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signed [10:0] lft_spd = '0;
  logic signed [10:0] rght_spd = '0;
  logic mtr_en = 1'b1;
  logic lft_pwm1, lft_pwm2, rght_pwm1, rght_pwm2, prd_start;

  mtr_pwm_drv #(.NONOVERLAP(NN), .DATA_W(11)) dut (
    .clk(clk), .rst_n(rst_n), .lft_spd(lft_spd), .rght_spd(rght_spd), .mtr_en(mtr_en),
    .lft_pwm1(lft_pwm1), .lft_pwm2(lft_pwm2), .rght_pwm1(rght_pwm1),
    .rght_pwm2(rght_pwm2), .prd_start(prd_start)
  );

  always #5 clk = ~clk;

  typedef struct {bit l1; bit l2; bit r1; bit r2; bit ps;} exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: counter position, duty of the current period, and the last
  // counter value in this period at which the enable was sampled low.
  int mcnt = 0;
  int duty_l = 1024;
  int duty_r = 1024;
  int last_dis = -1;

  function automatic bit on1(int c, int d, int ld);
    return (c >= NN + 1) && (c <= d) && (ld < NN);
  endfunction

  function automatic bit on2(int c, int d, int ld);
    return (c >= d + NN + 1) && (c <= 2047) && (ld < d + NN);
  endfunction

  task automatic chk(input string nm, input logic act, input logic expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at cnt %0d: got %b expected %b", nm, mcnt, act, expv);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    int c_old;
    exp_t e;
    if (!rst_n) begin
      mcnt = 0;
      duty_l = 1024;
      duty_r = 1024;
      last_dis = -1;
    end else begin
      c_old = mcnt;
      if (c_old == 2047) begin
        duty_l = int'(lft_spd) + 1024;
        duty_r = int'(rght_spd) + 1024;
        last_dis = -1;
      end else if (!mtr_en) begin
        last_dis = c_old;
      end
      mcnt = (c_old + 1) % 2048;
      e.l1 = on1(mcnt, duty_l, last_dis);
      e.l2 = on2(mcnt, duty_l, last_dis);
      e.r1 = on1(mcnt, duty_r, last_dis);
      e.r2 = on2(mcnt, duty_r, last_dis);
      e.ps = (mcnt == 0);
      q.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      chk("rst_lft_pwm1", lft_pwm1, 1'b0);
      chk("rst_lft_pwm2", lft_pwm2, 1'b0);
      chk("rst_rght_pwm1", rght_pwm1, 1'b0);
      chk("rst_rght_pwm2", rght_pwm2, 1'b0);
      chk("rst_prd_start", prd_start, 1'b1);
    end else if (q.size() > 0) begin
      e = q.pop_front();
      chk("lft_pwm1", lft_pwm1, e.l1);
      chk("lft_pwm2", lft_pwm2, e.l2);
      chk("rght_pwm1", rght_pwm1, e.r1);
      chk("rght_pwm2", rght_pwm2, e.r2);
      chk("prd_start", prd_start, e.ps);
      chk("lft_overlap", lft_pwm1 & lft_pwm2, 1'b0);
      chk("rght_overlap", rght_pwm1 & rght_pwm2, 1'b0);
    end
  end

  task automatic wait_cnt(input int c);
    do @(negedge clk); while (mcnt != c);
  endtask

  function automatic logic signed [10:0] pick_spd();
    int v;
    case ($urandom_range(0, 9))
      0: v = -1024;
      1: v = 1023;
      2: v = NN - 1 - 1024;
      3: v = NN - 1024;
      4: v = NN + 1 - 1024;
      5: v = 2047 - NN - 1024;
      6: v = 2046 - NN - 1024;
      7: v = 0;
      default: v = int'($urandom_range(0, 2047)) - 1024;
    endcase
    return 11'(v);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog at cnt %0d: got timeout expected completion", mcnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int chg;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Default 50% period, then a mid-period command that lands next period.
    wait_cnt(2047);
    wait_cnt(500);
    lft_spd = 11'sd256;
    wait_cnt(2046);
    wait_cnt(2046);

    // Full-scale commands in opposite directions.
    lft_spd = 11'sd1023;
    rght_spd = -11'sd1024;
    wait_cnt(2046);
    lft_spd = '0;
    rght_spd = '0;

    // Coast window across the low-side turn-on point.
    wait_cnt(700);
    mtr_en = 1'b0;
    wait_cnt(1500);
    mtr_en = 1'b1;
    wait_cnt(2047);

    // Asynchronous reset while the low side is on.
    wait_cnt(1200);
    #2 rst_n = 1'b0;
    #1;
    chk("async_lft_pwm2", lft_pwm2, 1'b0);
    chk("async_rght_pwm2", rght_pwm2, 1'b0);
    chk("async_prd_start", prd_start, 1'b1);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    wait_cnt(2047);

    // Randomized periods with boundary-heavy commands and enable toggles.
    for (int p = 0; p < 8; p++) begin
      chg = (p == 0) ? 2047 : int'($urandom_range(0, 2047));
      for (int k = 0; k < 2048; k++) begin
        @(negedge clk);
        if (mcnt == chg) begin
          lft_spd = pick_spd();
          rght_spd = pick_spd();
        end
        if ($urandom_range(0, 599) == 0) mtr_en = ~mtr_en;
      end
    end
    mtr_en = 1'b1;
    wait_cnt(2047);
    wait_cnt(2047);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
